// File: rtl/uart_rx_if.sv
// Receiver-side bundle for uart_rx: baud enable, serial line and the recovered byte with status.
// Optional feature macro: UART_RX_PARITY_EN (adds parityError).
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 clkEn;
  logic                 serialInput;
  logic [DATA_BITS-1:0] outputData;
  logic                 dataValid;
  logic                 busy;
  logic                 frameError;
`ifdef UART_RX_PARITY_EN
  logic                 parityError;

  modport master (
    output clkEn, serialInput,
    input  outputData, dataValid, busy, frameError, parityError
  );

  modport slave (
    input  clkEn, serialInput,
    output outputData, dataValid, busy, frameError, parityError
  );
`else
  modport master (
    output clkEn, serialInput,
    input  outputData, dataValid, busy, frameError
  );

  modport slave (
    input  clkEn, serialInput,
    output outputData, dataValid, busy, frameError
  );
`endif
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver (start + DATA_BITS + [even parity] + stop) with 3-sample majority voting.
// Optional feature macro: UART_RX_PARITY_EN (parity bit and parityError output).
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input logic    clk,
  input logic    rstN,
  uart_rx_if.slave rx
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] TICK_PRE  = TW'(M - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(M);
  localparam logic [TW-1:0] TICK_DEC  = TW'(M + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic even_parity_err(input logic [DATA_BITS-1:0] d, input logic p);
    return (^d) ^ p;
  endfunction

  logic                 sync1_r;
  logic                 sync2_r;
  state_t               state_r;
  logic [TW-1:0]        tick_r;
  logic [BW-1:0]        bit_idx_r;
  logic                 samp_a_r;
  logic                 samp_b_r;
  logic [DATA_BITS-1:0] shift_r;
  logic                 armed_r;
  logic [DATA_BITS-1:0] data_r;
  logic                 valid_r;
  logic                 busy_r;
  logic                 ferr_r;
`ifdef UART_RX_PARITY_EN
  logic                 parity_r;
  logic                 perr_r;
`endif

  logic                 rx_s;
  logic                 maj_s;
  logic [DATA_BITS:0]   shift_next_s;

  assign rx_s         = sync2_r;
  assign maj_s        = maj3(samp_a_r, samp_b_r, rx_s);
  assign shift_next_s = {maj_s, shift_r};

  // Two-flop synchronizer for the asynchronous line, idling high
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= rx.serialInput;
      sync2_r <= sync1_r;
    end
  end

  // Frame FSM, counters, sampling and registered outputs; everything advances on clkEn only
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_r   <= IDLE;
      tick_r    <= {TW{1'b0}};
      bit_idx_r <= {BW{1'b0}};
      samp_a_r  <= 1'b1;
      samp_b_r  <= 1'b1;
      shift_r   <= {DATA_BITS{1'b0}};
      armed_r   <= 1'b1;
      data_r    <= {DATA_BITS{1'b0}};
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      ferr_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_r  <= 1'b0;
      perr_r    <= 1'b0;
`endif
    end else begin
      valid_r <= 1'b0;
      if (rx.clkEn) begin
        if (tick_r == TICK_PRE) begin
          samp_a_r <= rx_s;
        end
        if (tick_r == TICK_MID) begin
          samp_b_r <= rx_s;
        end
        case (state_r)
          IDLE: begin
            // The detecting clkEn is tick 0, so the next one is tick 1
            if (!armed_r) begin
              tick_r <= {TW{1'b0}};
              if (rx_s) begin
                armed_r <= 1'b1;
              end
            end else if (!rx_s) begin
              state_r <= START;
              busy_r  <= 1'b1;
              tick_r  <= TW'(1);
            end else begin
              tick_r <= {TW{1'b0}};
            end
          end
          START: begin
            if ((tick_r == TICK_DEC) && maj_s) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              tick_r  <= {TW{1'b0}};
            end else if (tick_r == TICK_LAST) begin
              state_r   <= DATA;
              tick_r    <= {TW{1'b0}};
              bit_idx_r <= {BW{1'b0}};
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end
          DATA: begin
            if (tick_r == TICK_DEC) begin
              shift_r <= shift_next_s[DATA_BITS:1];
            end
            if (tick_r == TICK_LAST) begin
              tick_r <= {TW{1'b0}};
              if (bit_idx_r == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                state_r <= PARITY;
`else
                state_r <= STOP;
`endif
              end else begin
                bit_idx_r <= bit_idx_r + BW'(1);
              end
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end
`ifdef UART_RX_PARITY_EN
          PARITY: begin
            if (tick_r == TICK_DEC) begin
              parity_r <= maj_s;
            end
            if (tick_r == TICK_LAST) begin
              state_r <= STOP;
              tick_r  <= {TW{1'b0}};
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end
`endif
          STOP: begin
            // Leave half a bit early so a slightly fast transmitter cannot clip the next start bit
            if (tick_r == TICK_DEC) begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
              tick_r  <= {TW{1'b0}};
              data_r  <= shift_r;
              ferr_r  <= ~maj_s;
              valid_r <= 1'b1;
              armed_r <= maj_s;
`ifdef UART_RX_PARITY_EN
              perr_r  <= even_parity_err(shift_r, parity_r);
`endif
            end else begin
              tick_r <= tick_r + TW'(1);
            end
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            tick_r  <= {TW{1'b0}};
          end
        endcase
      end
    end
  end

  assign rx.outputData  = data_r;
  assign rx.dataValid   = valid_r;
  assign rx.busy        = busy_r;
  assign rx.frameError  = ferr_r;
`ifdef UART_RX_PARITY_EN
  assign rx.parityError = perr_r;
`else
  // Parity helper is only exercised when the parity bit exists
  logic unused_s;
  assign unused_s = even_parity_err(shift_r, 1'b0);
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected bytes, a monitor checks each dataValid.
module tb_uart_rx;
  localparam int OS  = 16;
  localparam int DB  = 8;
  localparam int DIV = 4;
  localparam int M   = OS / 2;

  logic clk  = 1'b0;
  logic rstN = 1'b0;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk  (clk),
    .rstN (rstN),
    .rx   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
  } exp_t;

  exp_t exp_q[$];
  int   total     = 0;
  int   bad       = 0;
  int   n_valid   = 0;
  int   exp_valid = 0;
  int   div_cnt   = 0;

  // clkEn: one clk wide every DIV clocks, changed on the falling edge
  initial begin
    bus.clkEn = 1'b0;
    forever begin
      @(negedge clk);
      bus.clkEn = (div_cnt == DIV - 1);
      div_cnt   = (div_cnt == DIV - 1) ? 0 : div_cnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic perr_of(input logic [7:0] d, input logic p);
`ifdef UART_RX_PARITY_EN
    return (^d) ^ p;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic cur_perr();
`ifdef UART_RX_PARITY_EN
    return bus.parityError;
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (bus.dataValid === 1'b1) begin
      n_valid++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got data %h ferr %b, expected no strobe",
                 bus.outputData, bus.frameError);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rx_frame", {23'd0, bus.outputData, bus.frameError, cur_perr()}, {23'd0, e});
      end
    end
  end

  task automatic wait_ticks(input int n);
    int k;
    k = 0;
    while (k < n) begin
      @(posedge clk);
      if (bus.clkEn) k++;
    end
    @(negedge clk);
  endtask

  task automatic push_exp(input logic [7:0] d, input logic ferr, input logic perr);
    exp_t e;
    e.data = d;
    e.ferr = ferr;
    e.perr = perr;
    exp_q.push_back(e);
    exp_valid++;
  endtask

  // glitch_bit >= 0 inverts the line for one tick at tick M of that data bit
  task automatic send_frame(input logic [7:0] d, input logic par, input int glitch_bit);
    push_exp(d, 1'b0, perr_of(d, par));
    bus.serialInput = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 8; i++) begin
      bus.serialInput = d[i];
      if (i == glitch_bit) begin
        wait_ticks(M);
        bus.serialInput = ~d[i];
        wait_ticks(1);
        bus.serialInput = d[i];
        wait_ticks(OS - M - 1);
      end else begin
        wait_ticks(OS);
      end
    end
`ifdef UART_RX_PARITY_EN
    bus.serialInput = par;
    wait_ticks(OS);
`endif
    bus.serialInput = 1'b1;
    wait_ticks(OS);
  endtask

  initial begin
    logic [7:0] d55;
    bus.serialInput = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("reset_data",  {24'd0, bus.outputData}, 32'd0);
    check("reset_valid", {31'd0, bus.dataValid}, 32'd0);
    check("reset_busy",  {31'd0, bus.busy}, 32'd0);
    check("reset_ferr",  {31'd0, bus.frameError}, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    wait_ticks(2 * OS);

    // 1: clean 0xA5, busy observed mid-frame and dropped afterwards
    fork
      send_frame(8'hA5, ^8'hA5, -1);
      begin
        wait_ticks(5 * OS);
        check("t1_busy_mid", {31'd0, bus.busy}, 32'd1);
      end
    join
    check("t1_busy_after", {31'd0, bus.busy}, 32'd0);
    check("t1_one_valid", n_valid, 32'd1);
    wait_ticks(OS);

    // 2: false start, line low for 4 ticks
    bus.serialInput = 1'b0;
    wait_ticks(4);
    bus.serialInput = 1'b1;
    wait_ticks(2);
    check("t2_busy_start", {31'd0, bus.busy}, 32'd1);
    wait_ticks(OS);
    check("t2_busy_drop", {31'd0, bus.busy}, 32'd0);
    check("t2_no_valid", n_valid, 32'd1);
    wait_ticks(OS);

    // 3: glitch in bit 2 of 0x3C
    send_frame(8'h3C, ^8'h3C, 2);
    wait_ticks(OS);

    // 4: break of 12 bit times, then 0x81
    push_exp(8'h00, 1'b1, 1'b0);
    bus.serialInput = 1'b0;
    wait_ticks(11 * OS + M);
    check("t4_no_rearm_busy", {31'd0, bus.busy}, 32'd0);
    wait_ticks(OS - M);
    bus.serialInput = 1'b1;
    wait_ticks(2 * OS);
    check("t4_one_break_valid", n_valid, 32'd3);
    send_frame(8'h81, ^8'h81, -1);
    wait_ticks(OS);

    // 5: back-to-back 0x00, 0xFF
    send_frame(8'h00, ^8'h00, -1);
    send_frame(8'hFF, ^8'hFF, -1);
    wait_ticks(OS);
    check("t5_two_valids", n_valid, 32'd6);

    // 6: reset asserted during bit 4 of 0x55
    d55 = 8'h55;
    bus.serialInput = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      bus.serialInput = d55[i];
      wait_ticks(OS);
    end
    bus.serialInput = d55[4];
    wait_ticks(M);
    rstN = 1'b0;
    bus.serialInput = 1'b1;
    #1;
    check("t6_rst_data", {24'd0, bus.outputData}, 32'd0);
    check("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
    check("t6_rst_ferr", {31'd0, bus.frameError}, 32'd0);
    repeat (3) @(negedge clk);
    rstN = 1'b1;
    wait_ticks(2 * OS);
    check("t6_no_valid", n_valid, 32'd6);
    send_frame(8'h96, ^8'h96, -1);
    wait_ticks(OS);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h5A, 1'b1, -1);
    wait_ticks(OS);
    send_frame(8'h5A, 1'b0, -1);
    wait_ticks(OS);
`endif

    wait_ticks(2 * OS);
    check("queue_empty", exp_q.size(), 32'd0);
    check("valid_count", n_valid, exp_valid);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
